// File: rtl/pkg_calculadora.sv
// rtl/pkg_calculadora.sv - shared state encoding and opcodes for the calculator controller
package pkg_calculadora;

    typedef enum logic [2:0] {
        S_OPERANDO_A = 3'd0,
        S_OPERACION  = 3'd1,
        S_OPERANDO_B = 3'd2,
        S_CALCULO    = 3'd3,
        S_RESULTADO  = 3'd4
    } t_estado_calc;

    localparam logic [1:0] OP_SUMA  = 2'b00;
    localparam logic [1:0] OP_RESTA = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

endpackage

// File: rtl/mod_ALU_generalizado.sv
// rtl/mod_ALU_generalizado.sv - combinational n-bit ALU: add, subtract, AND, OR (modulo 2^n_bits)
module mod_ALU_generalizado
    import pkg_calculadora::*;
#(
    parameter int n_bits = 8
) (
    input  logic [n_bits-1:0] a,
    input  logic [n_bits-1:0] b,
    input  logic [1:0]        operacion,
    output logic [n_bits-1:0] resultado
);

    // Subtraction is done as two's-complement addition so both arithmetic ops share one adder form
    always_comb begin
        resultado = '0;
        case (operacion)
            OP_SUMA:  resultado = a + b;
            OP_RESTA: resultado = a + (~b + {{(n_bits-1){1'b0}}, 1'b1});
            OP_AND:   resultado = a & b;
            OP_OR:    resultado = a | b;
            default:  resultado = '0;
        endcase
    end

endmodule

// File: rtl/mod_control_calculadora.sv
// rtl/mod_control_calculadora.sv - operand/opcode sequencing FSM for a keypad calculator
module mod_control_calculadora
    import pkg_calculadora::*;
#(
    parameter int n_bits = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [n_bits-1:0] dato_entrada,
    input  logic              dato_valido,
    input  logic [1:0]        operacion_entrada,
    input  logic              operacion_valida,
    input  logic              ejecutar,
    input  logic              limpiar,
    output logic [n_bits-1:0] resultado,
    output logic              resultado_valido,
    output logic              desborde,
    output logic [2:0]        estado,
    output logic              ocupado
);

    t_estado_calc      estado_q, estado_d;
    logic [n_bits-1:0] reg_a, reg_a_d;
    logic [n_bits-1:0] reg_b, reg_b_d;
    logic [1:0]        reg_op, reg_op_d;
    logic              b_cargado, b_cargado_d;
    logic [n_bits-1:0] resultado_d;
    logic              desborde_d;
    logic              valido_d;
    logic [n_bits-1:0] alu_res;
    logic              desborde_calc;

    mod_ALU_generalizado #(.n_bits(n_bits)) u_alu (
        .a         (reg_a),
        .b         (reg_b),
        .operacion (reg_op),
        .resultado (alu_res)
    );

    // Signed overflow of the pending add/subtract, judged from operand and result sign bits
    always_comb begin
        desborde_calc = 1'b0;
        case (reg_op)
            OP_SUMA:  desborde_calc = (reg_a[n_bits-1] == reg_b[n_bits-1]) &&
                                      (alu_res[n_bits-1] != reg_a[n_bits-1]);
            OP_RESTA: desborde_calc = (reg_a[n_bits-1] != reg_b[n_bits-1]) &&
                                      (alu_res[n_bits-1] != reg_a[n_bits-1]);
            default:  desborde_calc = 1'b0;
        endcase
    end

    // Next-state logic: strict strobe priority limpiar > ejecutar > operacion_valida > dato_valido,
    // a higher strobe swallows the lower ones even when the current state ignores it
    always_comb begin
        estado_d    = estado_q;
        reg_a_d     = reg_a;
        reg_b_d     = reg_b;
        reg_op_d    = reg_op;
        b_cargado_d = b_cargado;
        resultado_d = resultado;
        desborde_d  = desborde;
        valido_d    = 1'b0;
        if (limpiar) begin
            estado_d    = S_OPERANDO_A;
            reg_a_d     = '0;
            reg_b_d     = '0;
            reg_op_d    = '0;
            b_cargado_d = 1'b0;
            resultado_d = '0;
            desborde_d  = 1'b0;
        end else begin
            case (estado_q)
                S_OPERANDO_A: begin
                    if (!ejecutar && !operacion_valida && dato_valido) begin
                        reg_a_d  = dato_entrada;
                        estado_d = S_OPERACION;
                    end
                end
                S_OPERACION: begin
                    if (ejecutar) begin
                        estado_d = S_OPERACION;
                    end else if (operacion_valida) begin
                        reg_op_d = operacion_entrada;
                        estado_d = S_OPERANDO_B;
                    end else if (dato_valido) begin
                        reg_a_d = dato_entrada;
                    end
                end
                S_OPERANDO_B: begin
                    if (ejecutar) begin
                        if (b_cargado) estado_d = S_CALCULO;
                    end else if (operacion_valida) begin
                        reg_op_d = operacion_entrada;
                    end else if (dato_valido) begin
                        reg_b_d     = dato_entrada;
                        b_cargado_d = 1'b1;
                    end
                end
                S_CALCULO: begin
                    resultado_d = alu_res;
                    desborde_d  = desborde_calc;
                    valido_d    = 1'b1;
                    estado_d    = S_RESULTADO;
                end
                S_RESULTADO: begin
                    if (ejecutar) begin
                        estado_d = S_RESULTADO;
                    end else if (operacion_valida) begin
                        reg_a_d     = resultado;
                        reg_op_d    = operacion_entrada;
                        b_cargado_d = 1'b0;
                        estado_d    = S_OPERANDO_B;
                    end else if (dato_valido) begin
                        reg_a_d     = dato_entrada;
                        b_cargado_d = 1'b0;
                        estado_d    = S_OPERACION;
                    end
                end
                default: estado_d = S_OPERANDO_A;
            endcase
        end
    end

    // State and datapath registers; reset overrides every strobe and aborts a pending calculation
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q         <= S_OPERANDO_A;
            reg_a            <= '0;
            reg_b            <= '0;
            reg_op           <= '0;
            b_cargado        <= 1'b0;
            resultado        <= '0;
            desborde         <= 1'b0;
            resultado_valido <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            reg_a            <= reg_a_d;
            reg_b            <= reg_b_d;
            reg_op           <= reg_op_d;
            b_cargado        <= b_cargado_d;
            resultado        <= resultado_d;
            desborde         <= desborde_d;
            resultado_valido <= valido_d;
        end
    end

    assign estado  = estado_q;
    assign ocupado = (estado_q == S_CALCULO);

endmodule

// File: tb/tb_mod_control_calculadora.sv
// tb/tb_mod_control_calculadora.sv - directed vector bench for mod_control_calculadora
module tb_mod_control_calculadora;

    logic       clk;
    logic       reset;
    logic [7:0] dato_entrada;
    logic       dato_valido;
    logic [1:0] operacion_entrada;
    logic       operacion_valida;
    logic       ejecutar;
    logic       limpiar;
    logic [7:0] resultado;
    logic       resultado_valido;
    logic       desborde;
    logic [2:0] estado;
    logic       ocupado;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] dato;
        logic       dv;
        logic [1:0] op;
        logic       ov;
        logic       ej;
        logic       lp;
        logic [2:0] e_est;
        logic [7:0] e_res;
        logic       e_val;
        logic       e_des;
        logic       e_ocu;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] ST_A = 3'd0;
    localparam logic [2:0] ST_O = 3'd1;
    localparam logic [2:0] ST_B = 3'd2;
    localparam logic [2:0] ST_C = 3'd3;
    localparam logic [2:0] ST_R = 3'd4;

    mod_control_calculadora #(.n_bits(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .dato_entrada      (dato_entrada),
        .dato_valido       (dato_valido),
        .operacion_entrada (operacion_entrada),
        .operacion_valida  (operacion_valida),
        .ejecutar          (ejecutar),
        .limpiar           (limpiar),
        .resultado         (resultado),
        .resultado_valido  (resultado_valido),
        .desborde          (desborde),
        .estado            (estado),
        .ocupado           (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_est, input logic [7:0] e_res,
                             input logic e_val, input logic e_des, input logic e_ocu);
        check({tag, ".estado"}, {5'd0, estado}, {5'd0, e_est});
        check({tag, ".resultado"}, resultado, e_res);
        check({tag, ".valido"}, {7'd0, resultado_valido}, {7'd0, e_val});
        check({tag, ".desborde"}, {7'd0, desborde}, {7'd0, e_des});
        check({tag, ".ocupado"}, {7'd0, ocupado}, {7'd0, e_ocu});
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic [1:0] op,
                         input logic ov, input logic ej, input logic lp);
        dato_entrada      = d;
        dato_valido       = dv;
        operacion_entrada = op;
        operacion_valida  = ov;
        ejecutar          = ej;
        limpiar           = lp;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] d, input logic dv, input logic [1:0] op, input logic ov,
                       input logic ej, input logic lp, input logic [2:0] est, input logic [7:0] res,
                       input logic val, input logic des, input logic ocu);
        vec_t v;
        v.dato = d; v.dv = dv; v.op = op; v.ov = ov; v.ej = ej; v.lp = lp;
        v.e_est = est; v.e_res = res; v.e_val = val; v.e_des = des; v.e_ocu = ocu;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //   dato  dv  op     ov  ej  lp   estado res    val des ocu
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_A, 8'h00, 0, 0, 0); // ejecutar in S_OPERANDO_A ignored
        add(8'h05, 1, 2'b00, 0, 0, 0,   ST_O, 8'h00, 0, 0, 0);
        add(8'h00, 0, 2'b00, 1, 0, 0,   ST_B, 8'h00, 0, 0, 0);
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_B, 8'h00, 0, 0, 0); // ejecutar before any B ignored
        add(8'h03, 1, 2'b00, 0, 0, 0,   ST_B, 8'h00, 0, 0, 0);
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_C, 8'h00, 0, 0, 1);
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'h08, 1, 0, 0); // 5+3
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'h08, 0, 0, 0); // pulse is one cycle
        add(8'h00, 0, 2'b01, 1, 0, 0,   ST_B, 8'h08, 0, 0, 0); // chain subtract
        add(8'h0A, 1, 2'b00, 0, 0, 0,   ST_B, 8'h08, 0, 0, 0);
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_C, 8'h08, 0, 0, 1);
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'hFE, 1, 0, 0); // 8-10
        add(8'h00, 0, 2'b00, 0, 0, 1,   ST_A, 8'h00, 0, 0, 0); // limpiar
        add(8'h7F, 1, 2'b00, 0, 0, 0,   ST_O, 8'h00, 0, 0, 0);
        add(8'h00, 0, 2'b00, 1, 0, 0,   ST_B, 8'h00, 0, 0, 0);
        add(8'h01, 1, 2'b00, 0, 0, 0,   ST_B, 8'h00, 0, 0, 0);
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_C, 8'h00, 0, 0, 1);
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'h80, 1, 1, 0); // 7F+1 overflows
        add(8'h80, 1, 2'b00, 0, 0, 0,   ST_O, 8'h80, 0, 1, 0); // new calculation
        add(8'h00, 0, 2'b01, 1, 0, 0,   ST_B, 8'h80, 0, 1, 0);
        add(8'h01, 1, 2'b00, 0, 0, 0,   ST_B, 8'h80, 0, 1, 0);
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_C, 8'h80, 0, 1, 1); // result held through S_CALCULO
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'h7F, 1, 1, 0); // 80-1 overflows
        add(8'h0F, 1, 2'b00, 0, 0, 0,   ST_O, 8'h7F, 0, 1, 0);
        add(8'h55, 1, 2'b10, 1, 0, 0,   ST_B, 8'h7F, 0, 1, 0); // opcode wins over dato
        add(8'hF3, 1, 2'b00, 0, 0, 0,   ST_B, 8'h7F, 0, 1, 0);
        add(8'h00, 0, 2'b11, 1, 1, 0,   ST_C, 8'h7F, 0, 1, 1); // ejecutar wins, opcode dropped
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'h03, 1, 0, 0); // 0F & F3
        add(8'h00, 0, 2'b11, 1, 0, 0,   ST_B, 8'h03, 0, 0, 0);
        add(8'h30, 1, 2'b00, 0, 0, 0,   ST_B, 8'h03, 0, 0, 0);
        add(8'h00, 0, 2'b00, 0, 1, 0,   ST_C, 8'h03, 0, 0, 1);
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_R, 8'h33, 1, 0, 0); // 03 | 30
        add(8'h00, 0, 2'b11, 1, 0, 0,   ST_B, 8'h33, 0, 0, 0);
        add(8'h01, 1, 2'b00, 0, 0, 0,   ST_B, 8'h33, 0, 0, 0);
        add(8'h00, 0, 2'b00, 0, 1, 1,   ST_A, 8'h00, 0, 0, 0); // limpiar beats ejecutar
        add(8'h00, 0, 2'b00, 0, 0, 0,   ST_A, 8'h00, 0, 0, 0); // and no pulse follows

        reset = 1'b1;
        drive(8'h00, 0, 2'b00, 0, 0, 0);
        drive(8'h00, 0, 2'b00, 0, 0, 0);
        reset = 1'b0;
        check_all("reset", ST_A, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].dato, vecs[i].dv, vecs[i].op, vecs[i].ov, vecs[i].ej, vecs[i].lp);
            check_all($sformatf("vec%0d", i), vecs[i].e_est, vecs[i].e_res,
                      vecs[i].e_val, vecs[i].e_des, vecs[i].e_ocu);
        end

        // reset arriving while S_CALCULO is active aborts the operation
        drive(8'hF0, 1, 2'b00, 0, 0, 0);
        drive(8'h00, 0, 2'b00, 1, 0, 0);
        drive(8'h20, 1, 2'b00, 0, 0, 0);
        drive(8'h00, 0, 2'b00, 0, 1, 0);
        check_all("pre_abort", ST_C, 8'h00, 0, 0, 1);
        reset = 1'b1;
        drive(8'h00, 0, 2'b00, 0, 0, 0);
        reset = 1'b0;
        check_all("abort", ST_A, 8'h00, 0, 0, 0);
        drive(8'h00, 0, 2'b00, 0, 0, 0);
        check_all("abort_after", ST_A, 8'h00, 0, 0, 0);

        // reset overrides a simultaneous strobe
        reset = 1'b1;
        drive(8'h44, 1, 2'b00, 0, 0, 0);
        reset = 1'b0;
        check_all("reset_vs_dato", ST_A, 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_control_calculadora.md
MOD_CONTROL_CALCULADORA -- requirements
Module: mod_control_calculadora

Interface
REQ-001 Parameter: n_bits, default 8, operand/result width shared with the ALU.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous and active-high.
REQ-004 dato_entrada  in  n_bits  operand value from keypad/switches.
REQ-005 dato_valido  in  1  one-cycle strobe: dato_entrada is valid.
REQ-006 operacion_entrada  in  2  opcode: 00 add, 01 subtract, 10 AND, 11 OR.
REQ-007 operacion_valida  in  1  one-cycle strobe: operacion_entrada is valid.
REQ-008 ejecutar  in  1  one-cycle strobe: compute result ("=").
REQ-009 limpiar  in  1  one-cycle strobe: clear calculation ("C").
REQ-010 resultado  out  n_bits  registered result of last completed operation.
REQ-011 resultado_valido  out  1  one-cycle pulse when resultado updates.
REQ-012 desborde  out  1  signed overflow of last add/subtract, registered with resultado.
REQ-013 estado  out  3  current FSM state encoding, for display/debug.
REQ-014 ocupado  out  1  high while in S_CALCULO.

Function
REQ-015 FSM states: S_OPERANDO_A, S_OPERACION, S_OPERANDO_B, S_CALCULO, S_RESULTADO.
REQ-016 Input priority per cycle: limpiar > ejecutar > operacion_valida > dato_valido; lower-priority strobes in the same cycle are discarded.
REQ-017 limpiar in any state: registers A, B, opcode, resultado, desborde cleared to 0, b_cargado cleared, next state S_OPERANDO_A.
REQ-018 S_OPERANDO_A: dato_valido loads A, next S_OPERACION; other strobes ignored.
REQ-019 S_OPERACION: operacion_valida loads opcode, next S_OPERANDO_B; dato_valido reloads A, stays; ejecutar ignored.
REQ-020 S_OPERANDO_B: dato_valido loads B, sets b_cargado (last value wins); operacion_valida replaces opcode, stays; ejecutar with b_cargado=1 goes to S_CALCULO, with b_cargado=0 ignored.
REQ-021 S_CALCULO: lasts exactly one cycle; ALU output and desborde registered at its end; next S_RESULTADO; all strobes except limpiar ignored.
REQ-022 Latency: resultado and resultado_valido appear in the second cycle after the cycle ejecutar is sampled; resultado_valido high exactly one cycle.
REQ-023 S_RESULTADO: operacion_valida copies resultado into A, loads opcode, clears b_cargado, next S_OPERANDO_B (chained operation).
REQ-024 S_RESULTADO: dato_valido loads A, clears b_cargado, next S_OPERACION (new calculation); ejecutar ignored.
REQ-025 resultado and desborde hold their value until next S_CALCULO, limpiar or reset.
REQ-026 Arithmetic is modulo 2^n_bits; subtraction is A + (~B + 1); no width extension of resultado.
REQ-027 desborde: add = (A.msb == B.msb) and (R.msb != A.msb); subtract = (A.msb != B.msb) and (R.msb != A.msb); AND/OR = 0.
REQ-028 ocupado = 1 only in S_CALCULO.

Reset
REQ-029 reset high at a rising edge: state S_OPERANDO_A; A, B, opcode, resultado, desborde, resultado_valido, b_cargado all 0; overrides every strobe.
REQ-030 Reset during S_CALCULO aborts the operation; no resultado_valido pulse is produced.

Structure
REQ-031 Package pkg_calculadora holds the state enum t_estado_calc and opcode constants OP_SUMA, OP_RESTA, OP_AND, OP_OR.
REQ-032 One sub-module: mod_ALU_generalizado instantiated with n_bits, fed from registers A, B and opcode; no arithmetic duplicated in the controller except the desborde logic.
REQ-033 Single clocked process for state/registers plus combinational next-state logic; all outputs registered except estado and ocupado, which are decoded from state.

Verification (n_bits = 8)
REQ-034 A=0x05, op=00, B=0x03, ejecutar -> resultado=0x08, desborde=0, resultado_valido pulse 2 cycles after ejecutar.
REQ-035 A=0x7F, op=00, B=0x01, ejecutar -> resultado=0x80, desborde=1; then A=0x80, op=01, B=0x01 -> resultado=0x7F, desborde=1.
REQ-036 Chain: after resultado=0x08, op=01, B=0x0A, ejecutar -> resultado=0xFE, desborde=0.
REQ-037 ejecutar in S_OPERANDO_A, and in S_OPERANDO_B before any B -> no state change, no resultado_valido.
REQ-038 limpiar and ejecutar in same cycle in S_OPERANDO_B -> state S_OPERANDO_A, resultado=0x00, no pulse.
REQ-039 reset asserted during S_CALCULO -> next cycle state S_OPERANDO_A, all outputs 0, no resultado_valido pulse.
